// File: rtl/rst_seq_pkg.sv
// Shared state encoding, default parameters and sizing helpers for the DDR4 reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST      = 3'd0,
        ST_DDR_HOLD = 3'd1,
        ST_CAL_WAIT = 3'd2,
        ST_USR_HOLD = 3'd3,
        ST_RUN      = 3'd4,
        ST_FAIL     = 3'd5
    } seq_state_t;

    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_DDR_HOLD_CYC = 16;
    localparam int DEF_USR_HOLD_CYC = 8;
    localparam int DEF_CAL_TIMEOUT  = 1048576;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter only ever reaches max_count-1, so log2(max_count) bits suffice.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop synchronizer with asynchronous active-low clear; used for reset release and calib_done.
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] d_stage;
            logic [WIDTH-1:0] q_reg;

            if (gi == 0) begin : g_in
                assign d_stage = d;
            end else begin : g_chain
                assign d_stage = g_stage[gi-1].q_reg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else begin
                    q_reg <= d_stage;
                end
            end
        end
    endgenerate

    assign q = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/rst_seq.sv
// DDR4 reset sequencer: DDR hold, calibration wait, user hold, run.
// Optional calibration timeout and FAIL state enabled by macro RST_SEQ_TIMEOUT_EN.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int DDR_HOLD_CYC = DEF_DDR_HOLD_CYC,
    parameter int USR_HOLD_CYC = DEF_USR_HOLD_CYC,
    parameter int CAL_TIMEOUT  = DEF_CAL_TIMEOUT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       calib_done,
    output logic       ddr_rstn,
    output logic       usr_rstn,
    output logic       ready,
    output logic       cal_timeout,
    output logic [2:0] seq_state
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DDR_HOLD_CYC < 1 ||
            USR_HOLD_CYC < 1 || CAL_TIMEOUT < 1) begin : g_bad_param
            $error("rst_seq: illegal parameter value");
        end
    endgenerate

    localparam int HOLD_MAX = max_int(DDR_HOLD_CYC, USR_HOLD_CYC);
`ifdef RST_SEQ_TIMEOUT_EN
    localparam int CNT_MAX  = max_int(HOLD_MAX, CAL_TIMEOUT);
`else
    localparam int CNT_MAX  = HOLD_MAX;
`endif
    localparam int CNT_W    = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] DDR_LAST = CNT_W'(DDR_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] USR_LAST = CNT_W'(USR_HOLD_CYC - 1);
`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CAL_TIMEOUT - 1);
`endif

    logic             rst_s;
    logic             cal_s;
    seq_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ddr_rstn_reg;
    logic             usr_rstn_reg;
    logic             ready_reg;

    rst_seq_sync #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk   (clk),
        .rst_n (rstn),
        .d     (1'b1),
        .q     (rst_s)
    );

    rst_seq_sync #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_cal_sync (
        .clk   (clk),
        .rst_n (rstn),
        .d     (calib_done),
        .q     (cal_s)
    );

`ifdef RST_SEQ_TIMEOUT_EN
    logic cal_timeout_reg;
    assign cal_timeout = cal_timeout_reg;
`else
    assign cal_timeout = 1'b0;
`endif

    // Outputs are updated together with the state so every output is a flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= ST_RST;
            cnt_reg         <= '0;
            ddr_rstn_reg    <= 1'b0;
            usr_rstn_reg    <= 1'b0;
            ready_reg       <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            cal_timeout_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_RST: begin
                    cnt_reg <= '0;
                    if (rst_s) begin
                        state_reg <= ST_DDR_HOLD;
                    end
                end

                ST_DDR_HOLD: begin
                    if (cnt_reg == DDR_LAST) begin
                        state_reg    <= ST_CAL_WAIT;
                        cnt_reg      <= '0;
                        ddr_rstn_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                // A synchronized calib_done wins over an expiring timeout.
                ST_CAL_WAIT: begin
                    if (cal_s) begin
                        state_reg <= ST_USR_HOLD;
                        cnt_reg   <= '0;
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (cnt_reg == CAL_LAST) begin
                        state_reg       <= ST_FAIL;
                        cnt_reg         <= '0;
                        ddr_rstn_reg    <= 1'b0;
                        usr_rstn_reg    <= 1'b0;
                        ready_reg       <= 1'b0;
                        cal_timeout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
`endif
                end

                ST_USR_HOLD: begin
                    if (!cal_s) begin
                        state_reg <= ST_CAL_WAIT;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == USR_LAST) begin
                        state_reg    <= ST_RUN;
                        cnt_reg      <= '0;
                        usr_rstn_reg <= 1'b1;
                        ready_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                // Losing calibration only resets the user side; the controller keeps running.
                ST_RUN: begin
                    if (!cal_s) begin
                        state_reg    <= ST_CAL_WAIT;
                        cnt_reg      <= '0;
                        usr_rstn_reg <= 1'b0;
                        ready_reg    <= 1'b0;
                    end
                end

`ifdef RST_SEQ_TIMEOUT_EN
                ST_FAIL: begin
                    cnt_reg         <= '0;
                    ddr_rstn_reg    <= 1'b0;
                    usr_rstn_reg    <= 1'b0;
                    ready_reg       <= 1'b0;
                    cal_timeout_reg <= 1'b1;
                end
`endif

                default: begin
                    state_reg    <= ST_RST;
                    cnt_reg      <= '0;
                    ddr_rstn_reg <= 1'b0;
                    usr_rstn_reg <= 1'b0;
                    ready_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign ddr_rstn  = ddr_rstn_reg;
    assign usr_rstn  = usr_rstn_reg;
    assign ready     = ready_reg;
    assign seq_state = state_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Directed scoreboard bench for rst_seq; expected output vectors are queued with the cycle they
// must appear on. Cycle t0 is the first rising edge that samples a changed input.
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       calib_done;
    logic       ddr_rstn;
    logic       usr_rstn;
    logic       ready;
    logic       cal_timeout;
    logic [2:0] seq_state;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_mis  = 0;

    typedef struct {
        string      tag;
        int         cyc;
        logic [6:0] vec;
    } exp_t;

    exp_t sb[$];

    rst_seq #(
        .SYNC_STAGES  (2),
        .DDR_HOLD_CYC (16),
        .USR_HOLD_CYC (8),
        .CAL_TIMEOUT  (64)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .calib_done  (calib_done),
        .ddr_rstn    (ddr_rstn),
        .usr_rstn    (usr_rstn),
        .ready       (ready),
        .cal_timeout (cal_timeout),
        .seq_state   (seq_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Packed as {ddr_rstn, usr_rstn, ready, cal_timeout, seq_state}.
    function automatic logic [6:0] v(input logic d, input logic u, input logic r,
                                     input logic t, input logic [2:0] s);
        return {d, u, r, t, s};
    endfunction

    task automatic push(input string tag, input int at, input logic [6:0] vec);
        exp_t e;
        e.tag = tag;
        e.cyc = at;
        e.vec = vec;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t       e;
        logic [6:0] obs;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            obs = {ddr_rstn, usr_rstn, ready, cal_timeout, seq_state};
            n_cmp++;
            assert (obs === e.vec) else begin
                n_mis++;
                $error("FAIL %s @cyc %0d: observed %b required %b", e.tag, cyc, obs, e.vec);
            end
        end
    endtask

    task automatic run_to(input int c);
        check_now();
        while (cyc < c) begin
            @(negedge clk);
            check_now();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int r;
        int q;
        int p;
        int d;

        rstn       = 1'b0;
        calib_done = 1'b1;

        // Held in reset: everything low, state RST.
        push("reset_state", 3, v(0, 0, 0, 0, 3'd0));
        run_to(3);

        // Release with calib_done already high.
        rstn = 1'b1;
        t0   = cyc + 1;
        push("sync_latency",   t0 + 1,  v(0, 0, 0, 0, 3'd0));
        push("ddr_hold_entry", t0 + 2,  v(0, 0, 0, 0, 3'd1));
        push("ddr_hold_last",  t0 + 17, v(0, 0, 0, 0, 3'd1));
        push("ddr_release",    t0 + 18, v(1, 0, 0, 0, 3'd2));
        push("usr_hold_entry", t0 + 19, v(1, 0, 0, 0, 3'd3));
        push("usr_hold_last",  t0 + 26, v(1, 0, 0, 0, 3'd3));
        push("run_entry",      t0 + 27, v(1, 1, 1, 0, 3'd4));
        run_to(t0 + 27);

        // Calibration lost for 5 cycles while running, then recovery.
        calib_done = 1'b0;
        r = cyc + 1;
        push("run_sync_delay", r + 1, v(1, 1, 1, 0, 3'd4));
        push("run_drop",       r + 2, v(1, 0, 0, 0, 3'd2));
        run_to(r + 4);
        calib_done = 1'b1;
        q = r + 5;
        push("recal_wait",    q + 1,  v(1, 0, 0, 0, 3'd2));
        push("recal_hold",    q + 2,  v(1, 0, 0, 0, 3'd3));
        push("recal_hold_lt", q + 9,  v(1, 0, 0, 0, 3'd3));
        push("recal_run",     q + 10, v(1, 1, 1, 0, 3'd4));
        run_to(q + 10);

        // Glitchy calib_done: single-cycle pulses and a 7-cycle pulse never reach RUN.
        calib_done = 1'b0;
        r = cyc + 1;
        push("glitch_drop", r + 2, v(1, 0, 0, 0, 3'd2));
        run_to(r + 3);
        for (int k = 0; k < 3; k++) begin
            calib_done = 1'b1;
            p = cyc + 1;
            run_to(p);
            calib_done = 1'b0;
            push("glitch_enter", p + 2, v(1, 0, 0, 0, 3'd3));
            push("glitch_exit",  p + 3, v(1, 0, 0, 0, 3'd2));
            run_to(p + 4);
        end
        calib_done = 1'b1;
        p = cyc + 1;
        run_to(p + 6);
        calib_done = 1'b0;
        push("short_hold_last", p + 8, v(1, 0, 0, 0, 3'd3));
        push("short_hold_exit", p + 9, v(1, 0, 0, 0, 3'd2));
        run_to(p + 10);
        calib_done = 1'b1;
        p = cyc + 1;
        push("steady_hold_last", p + 9,  v(1, 0, 0, 0, 3'd3));
        push("steady_run",       p + 10, v(1, 1, 1, 0, 3'd4));
        run_to(p + 10);

        // Asynchronous reset while in USR_HOLD.
        calib_done = 1'b0;
        r = cyc + 1;
        run_to(r + 3);
        calib_done = 1'b1;
        p = cyc + 1;
        push("pre_reset_usr_hold", p + 2, v(1, 0, 0, 0, 3'd3));
        run_to(p + 3);
        rstn       = 1'b0;
        calib_done = 1'b0;
        #1;
        push("async_reset_usr_hold", cyc, v(0, 0, 0, 0, 3'd0));
        check_now();
        push("held_reset", cyc + 2, v(0, 0, 0, 0, 3'd0));
        run_to(cyc + 2);

        // Restart with calib_done low.
        rstn = 1'b1;
        t0   = cyc + 1;
        d    = t0 + 18;
        push("restart_ddr_hold", t0 + 2, v(0, 0, 0, 0, 3'd1));
        push("restart_ddr_rel",  d,      v(1, 0, 0, 0, 3'd2));
`ifdef RST_SEQ_TIMEOUT_EN
        push("timeout_edge_m1", d + 63, v(1, 0, 0, 0, 3'd2));
        push("timeout_fail",    d + 64, v(0, 0, 0, 1, 3'd5));
        push("fail_sticky",     d + 80, v(0, 0, 0, 1, 3'd5));
        run_to(d + 80);
        rstn = 1'b0;
        #1;
        push("async_reset_fail", cyc, v(0, 0, 0, 0, 3'd0));
        check_now();
        run_to(cyc + 2);
        rstn = 1'b1;
        t0   = cyc + 1;
        push("post_fail_restart", t0 + 2, v(0, 0, 0, 0, 3'd1));
        run_to(t0 + 2);
`else
        push("cal_wait_100", d + 100, v(1, 0, 0, 0, 3'd2));
        push("cal_wait_499", d + 499, v(1, 0, 0, 0, 3'd2));
        run_to(d + 499);
        calib_done = 1'b1;
        r = d + 500;
        push("late_cal_sync",  r + 1,  v(1, 0, 0, 0, 3'd2));
        push("late_usr_hold",  r + 2,  v(1, 0, 0, 0, 3'd3));
        push("late_hold_last", r + 9,  v(1, 0, 0, 0, 3'd3));
        push("late_run",       r + 10, v(1, 1, 1, 0, 3'd4));
        run_to(r + 10);
        calib_done = 1'b0;
        r = cyc + 1;
        push("no_timeout_enter", r + 2,   v(1, 0, 0, 0, 3'd2));
        push("no_timeout_200",   r + 200, v(1, 0, 0, 0, 3'd2));
        run_to(r + 200);
`endif

        if (sb.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard_drain: observed %0d pending required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
